// File: rtl/spi_reg_pkg.sv
// Shared FSM state type and frame-geometry helpers for the SPI register initiator.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_REQ  = 3'd5,
        ST_DONE    = 3'd6
    } spi_state_e;

    function automatic int hdr_len(input int addr_w);
        return 32'sd1 + addr_w;
    endfunction

    function automatic int frame_len(input int addr_w, input int reg_w);
        return hdr_len(addr_w) + reg_w;
    endfunction

endpackage

// File: rtl/spi_reg_initiator_if.sv
// Register-side access bus driven by the SPI register initiator.
interface spi_reg_initiator_if #(
    parameter int ADDR_W = 8,
    parameter int REG_W  = 8
);
    logic              wr_rdn;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic              we;
    logic [REG_W-1:0]  rdata;
    logic              ack;
    logic              err;

    modport master (
        output wr_rdn, addr, wdata, we,
        input  rdata, ack, err
    );

    modport slave (
        input  wr_rdn, addr, wdata, we,
        output rdata, ack, err
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/spi_reg_initiator.sv
// SPI (mode 0) target that turns {wr_rdn, addr, data} frames into register-bus accesses.
module spi_reg_initiator
    import spi_reg_pkg::*;
#(
    parameter int REG_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    spi_reg_initiator_if.master  bus,
    output logic                 frame_err
);
    localparam int HDR_LEN = hdr_len(ADDR_W);
    localparam int MAX_LEN = (HDR_LEN > REG_W) ? HDR_LEN : REG_W;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic              cs_s;
    logic              sclk_s;
    logic              mosi_s;
    logic              cs_d_r;
    logic              sclk_d_r;
    logic [1:0]        settle_r;
    logic              cs_armed_r;
    logic              sclk_rise_s;
    logic              sclk_fall_s;
    logic              cs_fall_s;
    logic              cs_rise_s;
    logic              frame_open_s;
    logic [REG_W-1:0]  tx_load_s;

    spi_state_e        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [ADDR_W-1:0] hdr_sr_r;
    logic [REG_W-2:0]  dat_sr_r;
    logic [REG_W-1:0]  tx_sr_r;
    logic              miso_r;
    logic              miso_oe_r;
    logic              wr_rdn_r;
    logic [ADDR_W-1:0] addr_r;
    logic [REG_W-1:0]  wdata_r;
    logic              we_r;
    logic              frame_err_r;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

    // Edge-detect taps; CS is only armed once the synchronizer has settled and seen CS high,
    // so a CS held low across reset release cannot start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_d_r     <= 1'b1;
            sclk_d_r   <= 1'b0;
            settle_r   <= 2'd0;
            cs_armed_r <= 1'b0;
        end else begin
            cs_d_r   <= cs_s;
            sclk_d_r <= sclk_s;
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end
            if ((settle_r == 2'd3) && cs_s) begin
                cs_armed_r <= 1'b1;
            end
        end
    end

    assign sclk_rise_s  = sclk_s & ~sclk_d_r;
    assign sclk_fall_s  = ~sclk_s & sclk_d_r;
    assign cs_fall_s    = ~cs_s & cs_d_r & cs_armed_r;
    assign cs_rise_s    = cs_s & ~cs_d_r;
    assign frame_open_s = (state_r == ST_HDR)     || (state_r == ST_RD_REQ) ||
                          (state_r == ST_WR_DATA) || (state_r == ST_RD_DATA);
    assign tx_load_s    = bus.err ? {REG_W{1'b0}} : bus.rdata;

    // Frame sequencer: shifting, register-bus handshake and MISO drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            hdr_sr_r    <= {ADDR_W{1'b0}};
            dat_sr_r    <= {(REG_W-1){1'b0}};
            tx_sr_r     <= {REG_W{1'b0}};
            miso_r      <= 1'b0;
            miso_oe_r   <= 1'b0;
            wr_rdn_r    <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {REG_W{1'b0}};
            we_r        <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            we_r        <= 1'b0;
            frame_err_r <= 1'b0;
            if (cs_rise_s) begin
                state_r     <= ST_IDLE;
                bit_cnt_r   <= {CNT_W{1'b0}};
                miso_r      <= 1'b0;
                miso_oe_r   <= 1'b0;
                frame_err_r <= frame_open_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_fall_s) begin
                            state_r   <= ST_HDR;
                            bit_cnt_r <= {CNT_W{1'b0}};
                            miso_r    <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise_s) begin
                            if (bit_cnt_r == CNT_W'(HDR_LEN - 1)) begin
                                wr_rdn_r  <= hdr_sr_r[ADDR_W-1];
                                addr_r    <= {hdr_sr_r[ADDR_W-2:0], mosi_s};
                                bit_cnt_r <= {CNT_W{1'b0}};
                                miso_oe_r <= 1'b1;
                                state_r   <= hdr_sr_r[ADDR_W-1] ? ST_WR_DATA : ST_RD_REQ;
                            end else begin
                                hdr_sr_r  <= {hdr_sr_r[ADDR_W-2:0], mosi_s};
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        if (bus.ack) begin
                            frame_err_r <= bus.err;
                            state_r     <= ST_RD_DATA;
                            if (sclk_fall_s) begin
                                miso_r  <= tx_load_s[REG_W-1];
                                tx_sr_r <= {tx_load_s[REG_W-2:0], 1'b0};
                            end else begin
                                tx_sr_r <= tx_load_s;
                            end
                        end else if (sclk_fall_s) begin
                            // Register side missed the first data bit: send zeros instead.
                            frame_err_r <= 1'b1;
                            tx_sr_r     <= {REG_W{1'b0}};
                            miso_r      <= 1'b0;
                            state_r     <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (sclk_fall_s) begin
                            miso_r  <= tx_sr_r[REG_W-1];
                            tx_sr_r <= {tx_sr_r[REG_W-2:0], 1'b0};
                        end
                        if (sclk_rise_s) begin
                            if (bit_cnt_r == CNT_W'(REG_W - 1)) begin
                                bit_cnt_r <= {CNT_W{1'b0}};
                                miso_r    <= 1'b0;
                                state_r   <= ST_DONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (sclk_rise_s) begin
                            if (bit_cnt_r == CNT_W'(REG_W - 1)) begin
                                wdata_r   <= {dat_sr_r, mosi_s};
                                we_r      <= 1'b1;
                                bit_cnt_r <= {CNT_W{1'b0}};
                                state_r   <= ST_WR_REQ;
                            end else begin
                                dat_sr_r  <= {dat_sr_r[REG_W-3:0], mosi_s};
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_WR_REQ: begin
                        if (bus.ack) begin
                            frame_err_r <= bus.err;
                            state_r     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = miso_r;
    assign spi_miso_oe = miso_oe_r;
    assign bus.wr_rdn  = wr_rdn_r;
    assign bus.addr    = addr_r;
    assign bus.wdata   = wdata_r;
    assign bus.we      = we_r;
    assign frame_err   = frame_err_r;
endmodule

// File: tb/tb_spi_reg_initiator.sv
// Scoreboard bench for spi_reg_initiator: randomized SPI frames against a register-map model.
module tb_spi_reg_initiator;
    localparam int ADDR_W    = 8;
    localparam int REG_W     = 8;
    localparam int HDR_LEN   = spi_reg_pkg::hdr_len(ADDR_W);
    localparam int FRAME_LEN = spi_reg_pkg::frame_len(ADDR_W, REG_W);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic spi_cs_n  = 1'b1;
    logic spi_sclk  = 1'b0;
    logic spi_mosi  = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;
    logic frame_err;
    logic ack_en    = 1'b1;
    logic err_en    = 1'b0;

    logic [7:0] slave_mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem   [256] = '{default: 8'h00};

    int checks     = 0;
    int errors     = 0;
    int ferr_total = 0;
    int exp_ferr   = 0;
    wr_t        exp_wr_q [$];
    logic [7:0] exp_rd_q [$];

    spi_reg_initiator_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus_if ();

    assign bus_if.rdata = slave_mem[bus_if.addr];
    assign bus_if.ack   = ack_en;
    assign bus_if.err   = err_en;

    spi_reg_initiator #(.REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .bus        (bus_if),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Register file on the bus side: stores accepted writes.
    always @(negedge clk) begin
        if (bus_if.we === 1'b1 && bus_if.err === 1'b0) begin
            slave_mem[bus_if.addr] <= bus_if.wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor and frame_err pulse counter.
    initial begin : mon_we
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus_if.we === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got addr %0h wdata %0h expected no strobe",
                             bus_if.addr, bus_if.wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("we_dir_addr_data", {15'd0, bus_if.wr_rdn, bus_if.addr, bus_if.wdata},
                        {15'd0, 1'b1, e.a, e.d});
                end
            end
            if (frame_err === 1'b1) ferr_total++;
        end
    end

    // MISO monitor: collects the data phase of every complete read frame.
    initial begin : mon_rd
        int         nb;
        logic       first_bit;
        logic       oe_ok;
        logic [7:0] got;
        logic [7:0] e;
        forever begin
            @(negedge spi_cs_n);
            nb        = 0;
            got       = 8'h00;
            oe_ok     = 1'b1;
            first_bit = 1'b0;
            while (spi_cs_n === 1'b0) begin
                @(posedge spi_sclk or posedge spi_cs_n);
                if (spi_cs_n === 1'b0) begin
                    if (nb == 0) first_bit = spi_mosi;
                    if (nb >= HDR_LEN && nb < FRAME_LEN) begin
                        got = {got[6:0], spi_miso};
                        if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
                    end
                    nb++;
                end
            end
            if (nb >= FRAME_LEN && first_bit == 1'b0) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %0h expected no read frame", got);
                end else begin
                    e = exp_rd_q.pop_front();
                    chk("read_oe_miso", {23'd0, oe_ok, got}, {23'd0, 1'b1, e});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        spi_mosi = b;
        repeat (5) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (5) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [FRAME_LEN-1:0] bits, input int nbits, input int gap);
        spi_cs_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < FRAME_LEN) send_bit(bits[FRAME_LEN-1-i]);
            else               send_bit(1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int nbits, input int gap);
        exp_wr_q.push_back('{a: a, d: d});
        if (err_en) exp_ferr++;
        else        ref_mem[a] = d;
        spi_frame({1'b1, a, d}, nbits, gap);
    endtask

    task automatic do_read(input logic [7:0] a);
        if (!ack_en || err_en) begin
            exp_rd_q.push_back(8'h00);
            exp_ferr++;
        end else begin
            exp_rd_q.push_back(ref_mem[a]);
        end
        spi_frame({1'b0, a, 8'($urandom)}, FRAME_LEN, 10);
    endtask

    task automatic checkpoint(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_ferr"}, ferr_total, exp_ferr);
        chk({tag, "_pending"}, exp_wr_q.size() + exp_rd_q.size(), 0);
        chk({tag, "_idle_pins"}, {30'd0, spi_miso_oe, spi_miso}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {11'd0, spi_miso, spi_miso_oe, bus_if.wr_rdn, bus_if.addr, bus_if.wdata,
                  bus_if.we, frame_err}, 32'd0);
    endtask

    // Stimulus: directed scenarios followed by randomized frames.
    initial begin : stim
        logic [7:0] a;
        logic [7:0] d;
        int         kind;
        int         n;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        do_write(8'h03, 8'hA5, FRAME_LEN, 10);
        checkpoint("wr_03_a5");

        do_write(8'h82, 8'h5C, FRAME_LEN, 10);
        do_read(8'h82);
        checkpoint("rd_82");
        chk("hold_after_read", {23'd0, bus_if.wr_rdn, bus_if.addr}, {23'd0, 1'b0, 8'h82});

        exp_ferr++;
        spi_frame({1'b1, 8'h44, 8'h99}, 12, 10);
        checkpoint("trunc12");

        ack_en = 1'b0;
        do_read(8'h03);
        ack_en = 1'b1;
        checkpoint("rd_noack");
        err_en = 1'b1;
        do_read(8'h03);
        err_en = 1'b0;
        checkpoint("rd_err");

        do_write(8'h01, 8'h11, FRAME_LEN, 4);
        do_write(8'h02, 8'h22, 20, 10);
        checkpoint("b2b");

        spi_cs_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) send_bit((i == 0) || (i == 6) || (i == 7) || (i == 8));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_midframe");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        checkpoint("after_rst");
        do_write(8'h07, 8'h3C, FRAME_LEN, 10);
        do_read(8'h07);
        checkpoint("post_rst_frame");

        for (int it = 0; it < 40; it++) begin
            a    = 8'($urandom_range(0, 15));
            d    = 8'($urandom);
            kind = $urandom_range(0, 6);
            case (kind)
                0: do_write(a, d, FRAME_LEN, 10);
                1: do_read(a);
                2: do_write(a, d, FRAME_LEN + $urandom_range(1, 4), 10);
                3: begin
                    n = $urandom_range(1, FRAME_LEN - 1);
                    exp_ferr++;
                    spi_frame({1'($urandom_range(0, 1)), a, d}, n, 10);
                end
                4: begin
                    ack_en = 1'b0;
                    do_read(a);
                    ack_en = 1'b1;
                end
                5: begin
                    err_en = 1'b1;
                    do_read(a);
                    err_en = 1'b0;
                end
                default: begin
                    err_en = 1'b1;
                    do_write(a, d, FRAME_LEN, 10);
                    err_en = 1'b0;
                end
            endcase
            checkpoint("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck handshake cannot hang the run.
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end
endmodule
